// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM states, prefix
// scancodes, keyb_char field positions and a parity helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    // keyb_char field positions
    localparam int unsigned KC_SEQ_MSB  = 31;
    localparam int unsigned KC_SEQ_LSB  = 24;
    localparam int unsigned KC_EXT_BIT  = 9;
    localparam int unsigned KC_REL_BIT  = 8;
    localparam int unsigned KC_CODE_MSB = 7;
    localparam int unsigned KC_CODE_LSB = 0;

    // Odd parity holds when the 8 data bits plus the parity bit have an odd
    // number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{par, data};
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// N-stage synchroniser for an asynchronous PS/2 line with a falling-edge
// pulse. The pulse is asserted in the same cycle the synchronised output
// first shows the low level, so a companion data line synchronised with the
// same depth is sampled in alignment with it.
module ps2_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic sync_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift chain resets to the bus idle level (1) so no edge follows reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= STAGES'({sync_q, din});
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign fall_o = prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronises ps2_clk/ps2_data, deframes 11-bit
// frames, folds E0/F0 prefixes into flags and publishes key events into a
// 32-bit register polled by the CPU.
// Optional feature: define PS2_PARITY_CHECK_EN to enforce odd parity.
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [31:0] keyb_char,
    output logic        key_event,
    output logic        frame_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic                   clk_fall;
    logic                   clk_sync_unused;
    logic [SYNC_STAGES-1:0] dsync_q;
    logic                   data_s;

    ps2_state_e             state_q;
    logic [2:0]             bitcnt_q;
    logic [7:0]             shreg_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [7:0]             seq_q;
    logic                   rel_q;
    logic                   ext_q;
    logic [31:0]            keyb_q;
    logic                   key_event_q;
    logic                   frame_err_q;
    logic                   timeout_hit;
`ifdef PS2_PARITY_CHECK_EN
    logic                   parity_err_q;
`endif

    ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (ps2_clk),
        .sync_o  (clk_sync_unused),
        .fall_o  (clk_fall)
    );

    // Data line synchroniser, same depth as the clock path for alignment.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dsync_q <= '1;
        end else begin
            dsync_q <= SYNC_STAGES'({dsync_q, ps2_data});
        end
    end

    assign data_s = dsync_q[SYNC_STAGES-1] | (clk_sync_unused & 1'b0);

    // An edge in the terminal cycle takes priority over the timeout.
    assign timeout_hit = (state_q != IDLE) && !clk_fall && (cnt_q == CNT_LAST);

    // Frame FSM, timeout counter, prefix flags and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            bitcnt_q     <= '0;
            shreg_q      <= '0;
            cnt_q        <= '0;
            seq_q        <= '0;
            rel_q        <= 1'b0;
            ext_q        <= 1'b0;
            keyb_q       <= '0;
            key_event_q  <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            key_event_q <= 1'b0;
            frame_err_q <= 1'b0;

            if (clk_fall || state_q == IDLE) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (timeout_hit) begin
                state_q     <= IDLE;
                frame_err_q <= 1'b1;
                rel_q       <= 1'b0;
                ext_q       <= 1'b0;
            end else if (clk_fall) begin
                case (state_q)
                    IDLE: begin
                        if (!data_s) begin
                            state_q  <= DATA;
                            bitcnt_q <= '0;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg_q <= {data_s, shreg_q[7:1]};
                        if (bitcnt_q == 3'd7) begin
                            state_q <= PARITY;
                        end else begin
                            bitcnt_q <= bitcnt_q + 3'd1;
                        end
                    end
                    PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        parity_err_q <= !odd_parity_ok(shreg_q, data_s);
`endif
                        state_q <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (!data_s) begin
                            frame_err_q <= 1'b1;
`ifdef PS2_PARITY_CHECK_EN
                        end else if (parity_err_q) begin
                            frame_err_q <= 1'b1;
`endif
                        end else if (shreg_q == PS2_BREAK) begin
                            rel_q <= 1'b1;
                        end else if (shreg_q == PS2_EXT) begin
                            ext_q <= 1'b1;
                        end else begin
                            keyb_q <= '0;
                            keyb_q[KC_SEQ_MSB:KC_SEQ_LSB]   <= seq_q + 8'd1;
                            keyb_q[KC_EXT_BIT]              <= ext_q;
                            keyb_q[KC_REL_BIT]              <= rel_q;
                            keyb_q[KC_CODE_MSB:KC_CODE_LSB] <= shreg_q;
                            seq_q       <= seq_q + 8'd1;
                            key_event_q <= 1'b1;
                            rel_q       <= 1'b0;
                            ext_q       <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign keyb_char = keyb_q;
    assign key_event = key_event_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Scoreboard bench for ps2_keyboard: stimulus pushes expected events, a
// monitor pops and compares whenever the DUT pulses key_event or frame_err.
module tb_ps2_keyboard;

    localparam int H  = 8;    // clk cycles per PS/2 half-period
    localparam int TO = 100;  // timeout used for the DUT

    typedef struct packed {
        logic        is_err;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [31:0] keyb_char;
    logic        key_event;
    logic        frame_err;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  s;
    logic [31:0] last_kc;

    always #5 clk = ~clk;

    ps2_keyboard #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .keyb_char (keyb_char),
        .key_event (key_event),
        .frame_err (frame_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_ev(input logic [31:0] v);
        q.push_back('{is_err: 1'b0, val: v});
    endtask

    task automatic push_err(input logic [31:0] v);
        q.push_back('{is_err: 1'b1, val: v});
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(~bad_stop);
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n && (key_event || frame_err)) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: key_event=%b frame_err=%b keyb_char=%h, none expected",
                         key_event, frame_err, keyb_char);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("event_kind", {30'b0, frame_err, key_event}, {30'b0, e.is_err, ~e.is_err});
                check("keyb_char", keyb_char, e.val);
            end
        end
    end

    initial begin
        repeat (4) @(negedge clk);
        check("reset_keyb", keyb_char, 32'h0);
        check("reset_pulses", {30'b0, key_event, frame_err}, 32'h0);
        reset_n = 1'b1;
        repeat (1000) @(negedge clk);
        check("idle_keyb", keyb_char, 32'h0);

        // Plain key
        push_ev(32'h0100001C);
        send_frame(8'h1C, 1'b0, 1'b0);
        check("a_key", keyb_char, 32'h0100001C);

        // Release prefix
        send_frame(8'hF0, 1'b0, 1'b0);
        check("after_f0", keyb_char, 32'h0100001C);
        push_ev(32'h0200011C);
        send_frame(8'h1C, 1'b0, 1'b0);

        // Extended release, then plain
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        push_ev(32'h03000375);
        send_frame(8'h75, 1'b0, 1'b0);
        push_ev(32'h04000075);
        send_frame(8'h75, 1'b0, 1'b0);

        // Bad stop bit
        push_err(32'h04000075);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("stop_err_keyb", keyb_char, 32'h04000075);

        // Wrong parity
`ifdef PS2_PARITY_CHECK_EN
        push_err(32'h04000075);
        s = 8'h05;
        last_kc = 32'h04000075;
`else
        push_ev(32'h0500001C);
        s = 8'h06;
        last_kc = 32'h0500001C;
`endif
        send_frame(8'h1C, 1'b1, 1'b0);

        // Stray edge with data high while idle
        push_err(last_kc);
        ps2_bit(1'b1);
        repeat (20) @(negedge clk);

        // Timeout mid-frame after a release prefix; the prefix must be dropped
        send_frame(8'hF0, 1'b0, 1'b0);
        push_err(last_kc);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        repeat (TO + 50) @(negedge clk);
        check("timeout_keyb", keyb_char, last_kc);
        push_ev({s, 14'b0, 2'b00, 8'h29});
        send_frame(8'h29, 1'b0, 1'b0);
        check("drain_1", 32'(q.size()), 32'h0);

        // Reset during a frame: no error pulse, everything cleared
        for (int i = 0; i < 5; i++) ps2_bit(i[0]);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("midframe_reset_keyb", keyb_char, 32'h0);

        // 256 events: sequence wraps FF -> 00
        for (int i = 0; i < 256; i++) begin
            push_ev({8'(i + 1), 14'b0, 2'b00, 8'h16});
            send_frame(8'h16, 1'b0, 1'b0);
            if (i == 254) check("seq_ff", keyb_char, 32'hFF000016);
        end
        check("seq_wrap", keyb_char, 32'h00000016);

        repeat (50) @(negedge clk);
        check("drain_final", 32'(q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
